fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write arbiter that shares one synchronous FIFO write port among NUM_REQ independent producers. Each producer presents data on a valid/ready handshake. The arbiter grants one producer at a time, optionally for a locked burst, and drives the FIFO's write_req/data_in/full interface directly. It sits immediately upstream of the FIFO and is the only block allowed to drive its write side.

## Interface
- DATA_WIDTH, 8, width of each data word; equals the FIFO's DATA_WIDTH.
- NUM_REQ, 4, number of producers; legal range 2..16.
- MAX_BURST, 4, maximum beats per grant when bursting is compiled in; legal range 1..255.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  NUM_REQ  per-producer data valid.
- req_data  input  NUM_REQ*DATA_WIDTH  producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  per-producer accept; at most one bit is high.
- fifo_write_req  output  1  write strobe to the FIFO.
- fifo_data_in  output  DATA_WIDTH  write data to the FIFO.
- fifo_full  input  1  FIFO full flag.
- grant_id  output  $clog2(NUM_REQ)  index of the currently granted producer; 0 when idle.
- busy  output  1  high while in state BURST.

## Operation
- States:
  - IDLE: no grant.
  - BURST: grant held by grant_id.
- Combinational outputs:
  - req_ready[i] = busy & (grant_id==i) & ~fifo_full.
  - A transfer happens in any cycle where req_valid[grant_id] & req_ready[grant_id].
  - fifo_write_req = transfer.
  - fifo_data_in = req_data slice of grant_id, or 0 when not busy.
- Round-robin arbitration:
  - The search starts at (last_winner+1) mod NUM_REQ and ascends with wrap-around.
  - The winner is the first index with req_valid high.
  - last_winner is updated on every grant.
- IDLE -> BURST: when any req_valid is high, latch the winner into grant_id, clear beat_cnt, set last_winner.
- While in BURST:
  - Each transfer increments beat_cnt (8-bit).
  - The burst ends on a transfer with beat_cnt==MAX_BURST-1, or in any cycle where req_valid[grant_id] is low.
- At burst end:
  - Re-arbitrate over the current req_valid, with the just-finished producer at lowest priority.
  - If there is a winner: stay in BURST with the new grant_id and beat_cnt=0.
  - Otherwise: go to IDLE and set grant_id=0.
- fifo_full high: the transfer stalls; grant and beat_cnt are held and the burst does not end. A full FIFO never ends a burst by itself.
- Simultaneous req_valid deassert and fifo_full: the burst ends (the valid rule wins).
- Producers must hold req_valid and data stable until req_ready is seen. Otherwise their data is not guaranteed to be written.

## Timing
- Reset values:
  - state IDLE, grant_id 0, busy 0, beat_cnt 0, last_winner NUM_REQ-1 (so producer 0 has first priority).
  - req_ready 0, fifo_write_req 0, fifo_data_in 0.
- A reset asserted mid-burst aborts the burst on the next edge. No partial-burst state survives.
- Latency from IDLE: req_valid seen at edge N gives busy and req_ready at cycle N+1, so the first write is at edge N+1.
- Back-to-back bursts: zero idle cycles between producers when another req_valid is pending at burst end.
- fifo_full to req_ready is combinational (zero cycles), so no write is ever issued to a full FIFO.
- Throughput: one word per cycle while the FIFO is not full.

## Configuration
- FIFO_ARB_BURST_EN defined: burst locking as described, up to MAX_BURST beats per grant.
- FIFO_ARB_BURST_EN undefined:
  - Every transfer ends the burst; MAX_BURST is ignored and beat_cnt is not implemented.
  - This gives strict per-word round-robin. A producer that is granted but drops req_valid releases the grant in that cycle.

## Test plan
- Reset: after rst held for 2 cycles, all outputs are 0, busy=0; with all four req_valid high, the first grant goes to producer 0 at the next cycle.
- Fairness (burst on, MAX_BURST=4): all four producers stream continuously with empty FIFO -> FIFO receives 4 words from 0, then 4 from 1, then 2, then 3, then 0 again, with no gaps.
- Early release: producer 2 sends 2 words then drops valid, producer 3 valid -> grant moves to 3 on the following edge; exactly 2 words from 2 are written.
- Full stall: fifo_full asserted mid-burst for 5 cycles -> fifo_write_req=0 and req_ready=0 during the stall, grant_id and beat_cnt unchanged, and the burst resumes afterwards with its remaining beats.
- Reset mid-burst: rst at beat 2 of producer 1's burst -> next cycle IDLE; after release, with producers 1 and 3 valid, producer 1 is granted first (priority reset).
- Burst off: all producers continuously valid -> the FIFO sequence is 0,1,2,3,0,1,... at one word per cycle.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that owns the FIFO write port. Define FIFO_ARB_BURST_EN to lock a grant for up to MAX_BURST beats.
// The grant is registered (one cycle from IDLE); req_ready and fifo_write_req follow fifo_full combinationally.
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int MAX_BURST  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          fifo_write_req,
   output logic [DATA_WIDTH-1:0]         fifo_data_in,
   input  logic                          fifo_full,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          busy
);
   localparam int GID_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_param_check
      $error("fifo_wr_arbiter: parameter out of range");
   end

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [GID_W-1:0]       grant_id_q, grant_id_d;
   logic [GID_W-1:0]       last_winner_q, last_winner_d;
   logic                   arb_found;
   logic [GID_W-1:0]       arb_winner;
   logic [GID_W:0]         rr_idx;
   logic                   grant_vld;
   logic [DATA_WIDTH-1:0]  grant_dat;
   logic                   transfer;
   logic                   last_beat;
   logic                   burst_end;

   // Search starts just after the last winner, so the previous grantee is considered last.
   always_comb begin
      arb_found  = 1'b0;
      arb_winner = '0;
      rr_idx     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         rr_idx = {1'b0, last_winner_q} + (GID_W+1)'(k);
         if (rr_idx >= (GID_W+1)'(NUM_REQ)) begin
            rr_idx = rr_idx - (GID_W+1)'(NUM_REQ);
         end
         if (!arb_found && req_valid[rr_idx[GID_W-1:0]]) begin
            arb_found  = 1'b1;
            arb_winner = rr_idx[GID_W-1:0];
         end
      end
   end

   always_comb begin
      grant_dat = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id_q == GID_W'(i)) begin
            grant_dat = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign busy           = (state_q == BURST);
   assign grant_id       = grant_id_q;
   assign grant_vld      = req_valid[grant_id_q];
   assign transfer       = busy & grant_vld & ~fifo_full;
   assign fifo_write_req = transfer;
   assign fifo_data_in   = busy ? grant_dat : '0;

   always_comb begin
      req_ready = '0;
      if (busy && !fifo_full) begin
         req_ready[grant_id_q] = 1'b1;
      end
   end

`ifdef FIFO_ARB_BURST_EN
   logic [7:0] beat_cnt_q, beat_cnt_d;
   assign last_beat = (beat_cnt_q == 8'(MAX_BURST - 1));
`else
   assign last_beat = 1'b1;
`endif

   // A stalled beat never ends the burst; a dropped valid always does.
   assign burst_end = busy & (~grant_vld | (transfer & last_beat));

   always_comb begin
      state_d       = state_q;
      grant_id_d    = grant_id_q;
      last_winner_d = last_winner_q;
`ifdef FIFO_ARB_BURST_EN
      beat_cnt_d    = beat_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (arb_found) begin
               state_d       = BURST;
               grant_id_d    = arb_winner;
               last_winner_d = arb_winner;
`ifdef FIFO_ARB_BURST_EN
               beat_cnt_d    = '0;
`endif
            end
         end
         BURST: begin
`ifdef FIFO_ARB_BURST_EN
            if (transfer) begin
               beat_cnt_d = beat_cnt_q + 8'd1;
            end
`endif
            if (burst_end) begin
`ifdef FIFO_ARB_BURST_EN
               beat_cnt_d = '0;
`endif
               if (arb_found) begin
                  grant_id_d    = arb_winner;
                  last_winner_d = arb_winner;
               end else begin
                  state_d    = IDLE;
                  grant_id_d = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         grant_id_q    <= '0;
         last_winner_q <= GID_W'(NUM_REQ - 1);
`ifdef FIFO_ARB_BURST_EN
         beat_cnt_q    <= '0;
`endif
      end else begin
         state_q       <= state_d;
         grant_id_q    <= grant_id_d;
         last_winner_q <= last_winner_d;
`ifdef FIFO_ARB_BURST_EN
         beat_cnt_q    <= beat_cnt_d;
`endif
      end
   end

endmodule
